// File: rtl/riscv_issue_scheduler.sv
// riscv_issue_scheduler: dual-issue in-order issue control with scoreboard, mul pipe and divider tracking
module riscv_issue_scheduler #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             slot0_valid_i,
  input  logic [4:0]       slot0_rd_i,
  input  logic [4:0]       slot0_ra_i,
  input  logic [4:0]       slot0_rb_i,
  input  logic             slot0_wr_i,
  input  logic             slot0_rda_i,
  input  logic             slot0_rdb_i,
  input  logic             slot0_load_i,
  input  logic             slot0_store_i,
  input  logic             slot0_mul_i,
  input  logic             slot0_div_i,
  input  logic             slot0_branch_i,
  input  logic             slot0_csr_i,
  input  logic             slot1_valid_i,
  input  logic [4:0]       slot1_rd_i,
  input  logic [4:0]       slot1_ra_i,
  input  logic [4:0]       slot1_rb_i,
  input  logic             slot1_wr_i,
  input  logic             slot1_rda_i,
  input  logic             slot1_rdb_i,
  input  logic             slot1_load_i,
  input  logic             slot1_store_i,
  input  logic             slot1_mul_i,
  input  logic             slot1_div_i,
  input  logic             slot1_branch_i,
  input  logic             slot1_csr_i,
  input  logic             exec_stall_i,
  input  logic             flush_i,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             div_done_i,
  output logic             issue0_o,
  output logic             issue1_o,
  output logic             div_busy_o,
  output logic [31:0]      pending_o,
  output logic [CNT_W-1:0] dual_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  logic [31:0] pending_q, pending_d, mul_busy, busy;
  logic [MUL_LAT-1:0] mul_v_q, mul_v_d;
  logic [MUL_LAT-1:0][4:0] mul_rd_q, mul_rd_d;
  logic div_busy_q, div_busy_d;
  logic [CNT_W-1:0] dual_cnt_q, stall_cnt_q;
  logic haz0, haz1, raw, waw, pair_conflict, iss0, iss1, mul_ld0, mul_ld1;
  always_comb begin
    mul_busy = '0;
    for (int i = 0; i < MUL_LAT; i++)
      if (mul_v_q[i]) mul_busy[mul_rd_q[i]] = 1'b1;
    busy = (pending_q | mul_busy) & ~32'd1;
  end
  assign haz0 = (slot0_rda_i & busy[slot0_ra_i]) | (slot0_rdb_i & busy[slot0_rb_i]) |
                (slot0_wr_i & busy[slot0_rd_i]) | ((slot0_mul_i | slot0_div_i) & div_busy_q);
  assign haz1 = (slot1_rda_i & busy[slot1_ra_i]) | (slot1_rdb_i & busy[slot1_rb_i]) |
                (slot1_wr_i & busy[slot1_rd_i]) | ((slot1_mul_i | slot1_div_i) & div_busy_q);
  assign raw = slot0_wr_i & |slot0_rd_i & ((slot1_rda_i & slot1_ra_i == slot0_rd_i) |
               (slot1_rdb_i & slot1_rb_i == slot0_rd_i));
  assign waw = slot0_wr_i & slot1_wr_i & |slot0_rd_i & slot0_rd_i == slot1_rd_i;
  assign pair_conflict = ((slot0_load_i | slot0_store_i) & (slot1_load_i | slot1_store_i)) |
                         ((slot0_mul_i | slot0_div_i) & (slot1_mul_i | slot1_div_i)) |
                         (slot0_branch_i & slot1_branch_i) | slot0_csr_i | slot1_csr_i | raw | waw;
  // Outputs are forced low while reset is asserted since reset is asynchronous.
  assign iss0 = rst_ni & slot0_valid_i & !exec_stall_i & !flush_i & !haz0;
  assign iss1 = iss0 & slot1_valid_i & !haz1 & !pair_conflict;
  assign mul_ld0 = iss0 & slot0_mul_i & slot0_wr_i & |slot0_rd_i;
  assign mul_ld1 = iss1 & slot1_mul_i & slot1_wr_i & |slot1_rd_i;
  always_comb begin
    pending_d = pending_q;
    if (wb_valid_i) pending_d[wb_rd_i] = 1'b0;
    if (iss0 & (slot0_load_i | slot0_div_i) & slot0_wr_i & |slot0_rd_i) pending_d[slot0_rd_i] = 1'b1;
    if (iss1 & (slot1_load_i | slot1_div_i) & slot1_wr_i & |slot1_rd_i) pending_d[slot1_rd_i] = 1'b1;
    mul_v_d = mul_v_q;
    mul_rd_d = mul_rd_q;
    mul_v_d[0] = mul_ld0 | mul_ld1;
    mul_rd_d[0] = mul_ld0 ? slot0_rd_i : slot1_rd_i;
    for (int i = 1; i < MUL_LAT; i++) begin
      mul_v_d[i] = mul_v_q[i-1];
      mul_rd_d[i] = mul_rd_q[i-1];
    end
    div_busy_d = (iss0 & slot0_div_i) | (iss1 & slot1_div_i) | (div_busy_q & !div_done_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      mul_v_q <= '0;
      mul_rd_q <= '0;
      div_busy_q <= 1'b0;
      dual_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      mul_v_q <= mul_v_d;
      mul_rd_q <= mul_rd_d;
      div_busy_q <= div_busy_d;
      if (iss1) dual_cnt_q <= dual_cnt_q + CNT_W'(1);
      if (slot0_valid_i & !iss0) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end
  assign issue0_o = iss0;
  assign issue1_o = iss1;
  assign div_busy_o = div_busy_q;
  assign pending_o = pending_q;
  assign dual_cnt_o = dual_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_riscv_issue_scheduler.sv
// tb_riscv_issue_scheduler: directed scenario tests for the dual-issue scheduler
module tb_riscv_issue_scheduler;
  localparam logic [8:0] ALU = 9'b111_000000;
  localparam logic [8:0] LW  = 9'b110_000001;
  localparam logic [8:0] SW  = 9'b011_000010;
  localparam logic [8:0] MUL = 9'b111_000100;
  localparam logic [8:0] DIV = 9'b111_001000;
  localparam logic [8:0] BR  = 9'b011_010000;
  localparam logic [8:0] CSR = 9'b110_100000;
  logic clk = 1'b0, rst_n;
  logic s0_valid, s0_wr, s0_rda, s0_rdb, s0_load, s0_store, s0_mul, s0_div, s0_branch, s0_csr;
  logic s1_valid, s1_wr, s1_rda, s1_rdb, s1_load, s1_store, s1_mul, s1_div, s1_branch, s1_csr;
  logic [4:0] s0_rd, s0_ra, s0_rb, s1_rd, s1_ra, s1_rb, wb_rd;
  logic exec_stall, flush, wb_valid, div_done;
  logic issue0, issue1, div_busy;
  logic [31:0] pending, dual_cnt, stall_cnt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  riscv_issue_scheduler #(.MUL_LAT(2), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slot0_valid_i(s0_valid), .slot0_rd_i(s0_rd), .slot0_ra_i(s0_ra), .slot0_rb_i(s0_rb),
    .slot0_wr_i(s0_wr), .slot0_rda_i(s0_rda), .slot0_rdb_i(s0_rdb),
    .slot0_load_i(s0_load), .slot0_store_i(s0_store), .slot0_mul_i(s0_mul), .slot0_div_i(s0_div),
    .slot0_branch_i(s0_branch), .slot0_csr_i(s0_csr),
    .slot1_valid_i(s1_valid), .slot1_rd_i(s1_rd), .slot1_ra_i(s1_ra), .slot1_rb_i(s1_rb),
    .slot1_wr_i(s1_wr), .slot1_rda_i(s1_rda), .slot1_rdb_i(s1_rdb),
    .slot1_load_i(s1_load), .slot1_store_i(s1_store), .slot1_mul_i(s1_mul), .slot1_div_i(s1_div),
    .slot1_branch_i(s1_branch), .slot1_csr_i(s1_csr),
    .exec_stall_i(exec_stall), .flush_i(flush), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .div_done_i(div_done), .issue0_o(issue0), .issue1_o(issue1), .div_busy_o(div_busy),
    .pending_o(pending), .dual_cnt_o(dual_cnt), .stall_cnt_o(stall_cnt)
  );
  task automatic s0(input logic [4:0] rd, ra, rb, input logic [8:0] f);
    s0_valid = 1'b1; s0_rd = rd; s0_ra = ra; s0_rb = rb;
    {s0_wr, s0_rda, s0_rdb, s0_csr, s0_branch, s0_div, s0_mul, s0_store, s0_load} = f;
  endtask
  task automatic s1(input logic [4:0] rd, ra, rb, input logic [8:0] f);
    s1_valid = 1'b1; s1_rd = rd; s1_ra = ra; s1_rb = rb;
    {s1_wr, s1_rda, s1_rdb, s1_csr, s1_branch, s1_div, s1_mul, s1_store, s1_load} = f;
  endtask
  task automatic idle();
    s0_valid = 1'b0; s0_rd = '0; s0_ra = '0; s0_rb = '0;
    {s0_wr, s0_rda, s0_rdb, s0_csr, s0_branch, s0_div, s0_mul, s0_store, s0_load} = '0;
    s1_valid = 1'b0; s1_rd = '0; s1_ra = '0; s1_rb = '0;
    {s1_wr, s1_rda, s1_rdb, s1_csr, s1_branch, s1_div, s1_mul, s1_store, s1_load} = '0;
    exec_stall = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0; div_done = 1'b0;
  endtask
  task automatic cyc();
    @(posedge clk); #1; idle();
  endtask
  task automatic test_reset();
    rst_n = 1'b0; idle(); s0(5, 1, 2, ALU); s1(6, 3, 4, ALU); #1;
    tests++; if (issue0 !== 1'b0) begin fails++; $display("FAIL reset_issue0: got %b exp 0", issue0); end
    tests++; if (issue1 !== 1'b0) begin fails++; $display("FAIL reset_issue1: got %b exp 0", issue1); end
    tests++; if (pending !== 32'h0) begin fails++; $display("FAIL reset_pending: got %h exp 0", pending); end
    tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL reset_div_busy: got %b exp 0", div_busy); end
    tests++; if (dual_cnt !== 32'd0 || stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", dual_cnt, stall_cnt); end
    idle(); #1; rst_n = 1'b1; cyc();
  endtask
  task automatic test_independent();
    s0(5, 1, 2, ALU); s1(6, 3, 4, ALU); #1;
    tests++; if ({issue0, issue1} !== 2'b11) begin fails++; $display("FAIL indep_issue: got %b exp 11", {issue0, issue1}); end
    cyc();
    tests++; if (dual_cnt !== 32'd1) begin fails++; $display("FAIL indep_dual_cnt: got %0d exp 1", dual_cnt); end
  endtask
  task automatic test_raw();
    s0(5, 1, 2, ALU); s1(10, 5, 3, ALU); #1;
    tests++; if ({issue0, issue1} !== 2'b10) begin fails++; $display("FAIL raw_pair: got %b exp 10", {issue0, issue1}); end
    cyc();
    s0(10, 5, 3, ALU); #1;
    tests++; if (issue0 !== 1'b1) begin fails++; $display("FAIL raw_moved: got %b exp 1", issue0); end
    cyc();
    s0(0, 1, 2, ALU); s1(11, 0, 0, ALU); #1;
    tests++; if ({issue0, issue1} !== 2'b11) begin fails++; $display("FAIL raw_x0: got %b exp 11", {issue0, issue1}); end
    cyc();
    tests++; if (dual_cnt !== 32'd2) begin fails++; $display("FAIL raw_dual_cnt: got %0d exp 2", dual_cnt); end
  endtask
  task automatic test_pair_conflicts();
    s0(12, 1, 0, LW); s1(0, 2, 3, SW); #1;
    tests++; if ({issue0, issue1} !== 2'b10) begin fails++; $display("FAIL conf_lsu: got %b exp 10", {issue0, issue1}); end
    s0(14, 1, 2, MUL); s1(15, 3, 4, DIV); #1;
    tests++; if ({issue0, issue1} !== 2'b10) begin fails++; $display("FAIL conf_muldiv: got %b exp 10", {issue0, issue1}); end
    s0(0, 1, 2, BR); s1(0, 3, 4, BR); #1;
    tests++; if ({issue0, issue1} !== 2'b10) begin fails++; $display("FAIL conf_branch: got %b exp 10", {issue0, issue1}); end
    s0(5, 1, 2, ALU); s1(6, 3, 0, CSR); #1;
    tests++; if ({issue0, issue1} !== 2'b10) begin fails++; $display("FAIL conf_csr: got %b exp 10", {issue0, issue1}); end
    idle(); cyc();
    s0(5, 1, 2, ALU); s1(5, 3, 4, ALU); #1;
    tests++; if ({issue0, issue1} !== 2'b10) begin fails++; $display("FAIL conf_waw: got %b exp 10", {issue0, issue1}); end
    s0(5, 1, 2, ALU); s1(6, 1, 5, ALU); #1;
    tests++; if ({issue0, issue1} !== 2'b10) begin fails++; $display("FAIL conf_raw_rb: got %b exp 10", {issue0, issue1}); end
    idle(); s1(6, 1, 2, ALU); #1;
    tests++; if ({issue0, issue1} !== 2'b00) begin fails++; $display("FAIL conf_slot1_alone: got %b exp 00", {issue0, issue1}); end
    s0(5, 1, 2, ALU); exec_stall = 1'b1; #1;
    tests++; if ({issue0, issue1} !== 2'b00) begin fails++; $display("FAIL conf_exec_stall: got %b exp 00", {issue0, issue1}); end
    idle(); cyc();
    tests++; if (stall_cnt !== 32'd0 || dual_cnt !== 32'd2) begin fails++; $display("FAIL conf_cnt: got %0d/%0d exp 0/2", stall_cnt, dual_cnt); end
  endtask
  task automatic test_load_use();
    s0(7, 1, 0, LW); #1;
    tests++; if (issue0 !== 1'b1) begin fails++; $display("FAIL lu_load_issue: got %b exp 1", issue0); end
    cyc();
    tests++; if (pending !== 32'h80) begin fails++; $display("FAIL lu_pending_set: got %h exp 80", pending); end
    for (int i = 0; i < 2; i++) begin
      s0(11, 7, 2, ALU); #1;
      tests++; if (issue0 !== 1'b0) begin fails++; $display("FAIL lu_blocked: got %b exp 0", issue0); end
      cyc();
    end
    s0(11, 7, 2, ALU); wb_valid = 1'b1; wb_rd = 5'd7; #1;
    tests++; if (issue0 !== 1'b0) begin fails++; $display("FAIL lu_wb_cycle: got %b exp 0", issue0); end
    cyc();
    tests++; if (pending !== 32'h0 || stall_cnt !== 32'd3) begin fails++; $display("FAIL lu_cleared: got %h/%0d exp 0/3", pending, stall_cnt); end
    s0(11, 7, 2, ALU); #1;
    tests++; if (issue0 !== 1'b1) begin fails++; $display("FAIL lu_add_issue: got %b exp 1", issue0); end
    cyc();
    s0(12, 1, 0, LW); s1(0, 2, 3, SW); #1; cyc();
    tests++; if (pending !== 32'h1000) begin fails++; $display("FAIL lu_pending12: got %h exp 1000", pending); end
    wb_valid = 1'b1; wb_rd = 5'd12; cyc();
    s0(13, 1, 0, LW); wb_valid = 1'b1; wb_rd = 5'd13; #1; cyc();
    tests++; if (pending !== 32'h2000) begin fails++; $display("FAIL lu_set_wins: got %h exp 2000", pending); end
    wb_valid = 1'b1; wb_rd = 5'd13; cyc();
    tests++; if (pending !== 32'h0) begin fails++; $display("FAIL lu_clear13: got %h exp 0", pending); end
  endtask
  task automatic test_div();
    s0(8, 1, 2, DIV); #1;
    tests++; if (issue0 !== 1'b1) begin fails++; $display("FAIL div_issue: got %b exp 1", issue0); end
    cyc();
    tests++; if (div_busy !== 1'b1 || pending !== 32'h100) begin fails++; $display("FAIL div_busy_set: got %b/%h exp 1/100", div_busy, pending); end
    for (int i = 0; i < 10; i++) begin
      s0(9, 3, 4, MUL); #1;
      tests++; if (issue0 !== 1'b0) begin fails++; $display("FAIL div_mul_blocked_%0d: got %b exp 0", i, issue0); end
      cyc();
    end
    s0(9, 3, 4, MUL); div_done = 1'b1; #1;
    tests++; if (issue0 !== 1'b0) begin fails++; $display("FAIL div_done_cycle: got %b exp 0", issue0); end
    cyc();
    tests++; if (div_busy !== 1'b0 || pending !== 32'h100 || stall_cnt !== 32'd14) begin fails++; $display("FAIL div_done: got %b/%h/%0d exp 0/100/14", div_busy, pending, stall_cnt); end
    s0(9, 3, 4, MUL); #1;
    tests++; if (issue0 !== 1'b1) begin fails++; $display("FAIL div_mul_issue: got %b exp 1", issue0); end
    cyc(); cyc(); cyc();
    wb_valid = 1'b1; wb_rd = 5'd8; cyc();
    tests++; if (pending !== 32'h0) begin fails++; $display("FAIL div_wb: got %h exp 0", pending); end
  endtask
  task automatic test_mul_latency();
    s0(9, 1, 2, MUL); #1;
    tests++; if (issue0 !== 1'b1) begin fails++; $display("FAIL mul_issue: got %b exp 1", issue0); end
    cyc();
    for (int i = 1; i <= 2; i++) begin
      s0(16, 9, 3, ALU); #1;
      tests++; if (issue0 !== 1'b0) begin fails++; $display("FAIL mul_dep_t%0d: got %b exp 0", i, issue0); end
      cyc();
    end
    s0(16, 9, 3, ALU); #1;
    tests++; if (issue0 !== 1'b1) begin fails++; $display("FAIL mul_dep_t3: got %b exp 1", issue0); end
    cyc();
    tests++; if (stall_cnt !== 32'd16 || pending !== 32'h0) begin fails++; $display("FAIL mul_state: got %0d/%h exp 16/0", stall_cnt, pending); end
    s0(0, 1, 2, MUL); #1; cyc();
    s0(17, 0, 3, ALU); #1;
    tests++; if (issue0 !== 1'b1) begin fails++; $display("FAIL mul_x0: got %b exp 1", issue0); end
    cyc();
  endtask
  task automatic test_flush_reset();
    s0(7, 1, 0, LW); s1(0, 2, 3, DIV); #1;
    tests++; if ({issue0, issue1} !== 2'b11) begin fails++; $display("FAIL fr_pair: got %b exp 11", {issue0, issue1}); end
    cyc();
    tests++; if (pending !== 32'h80 || div_busy !== 1'b1 || dual_cnt !== 32'd3) begin fails++; $display("FAIL fr_state: got %h/%b/%0d exp 80/1/3", pending, div_busy, dual_cnt); end
    s0(20, 1, 2, ALU); s1(21, 3, 4, ALU); flush = 1'b1; #1;
    tests++; if ({issue0, issue1} !== 2'b00) begin fails++; $display("FAIL fr_flush: got %b exp 00", {issue0, issue1}); end
    cyc();
    tests++; if (pending !== 32'h80 || div_busy !== 1'b1 || stall_cnt !== 32'd17) begin fails++; $display("FAIL fr_kept: got %h/%b/%0d exp 80/1/17", pending, div_busy, stall_cnt); end
    s0(20, 1, 2, ALU); rst_n = 1'b0; #1;
    tests++; if (pending !== 32'h0 || div_busy !== 1'b0) begin fails++; $display("FAIL fr_async_reset: got %h/%b exp 0/0", pending, div_busy); end
    tests++; if (dual_cnt !== 32'd0 || stall_cnt !== 32'd0 || issue0 !== 1'b0) begin fails++; $display("FAIL fr_reset_cnt: got %0d/%0d/%b exp 0/0/0", dual_cnt, stall_cnt, issue0); end
    #2; idle(); rst_n = 1'b1; cyc();
  endtask
  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_pair_conflicts();
    test_load_use();
    test_div();
    test_mul_latency();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
